// File: rtl/imm_ext_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : imm_ext_pipe_if
//  Description : Request/response bundle for the immediate generator.
//                The master drives requests and out_ready; the slave (the
//                generator) drives in_ready, out_valid, out_data and err.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imm_ext_pipe_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [2:0]        mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              err;

    modport master (
        output in_valid, imm, pc, mode, out_ready,
        input  in_ready, out_valid, out_data, err
    );

    modport slave (
        input  in_valid, imm, pc, mode, out_ready,
        output in_ready, out_valid, out_data, err
    );
endinterface
`default_nettype wire

// File: rtl/imm_ext_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_ext_pipe
//  Description : Pipelined MIPS immediate generator. Produces sign/zero
//                extended immediates, shifted branch offsets, jump targets
//                and LUI values behind a valid/ready output register with a
//                one-entry skid buffer (2 results of storage in total).
//                Optional macro IMM_EXT_ERR_EN builds a sticky illegal-mode
//                flag on err; without it err is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_pipe #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int JMP_W  = 26,
    parameter int SHAMT  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    imm_ext_pipe_if.slave  bus
);

    // Reject parameter sets where the jump field or immediate cannot fit
    generate
        if ((JMP_W + SHAMT >= DATA_W) || (IMM_W > DATA_W)) begin : g_param_check
            $error("imm_ext_pipe: illegal parameters (need JMP_W+SHAMT < DATA_W, IMM_W <= DATA_W)");
        end
    endgenerate

    localparam logic [2:0] C_MODE_SEXT = 3'd0;
    localparam logic [2:0] C_MODE_BOFS = 3'd1;
    localparam logic [2:0] C_MODE_JMP  = 3'd2;
    localparam logic [2:0] C_MODE_ZEXT = 3'd3;
    localparam logic [2:0] C_MODE_LUI  = 3'd4;

    // Bits of PC below this boundary are replaced by the jump index
    localparam logic [DATA_W-1:0] C_JMP_LO_MASK =
        (DATA_W'(1) << (JMP_W + SHAMT)) - DATA_W'(1);

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_in_ready;
    logic              r_err;

    logic              w_accept;
    logic              w_deliver;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_result;
    logic              w_main_valid_nxt;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic              w_skid_valid_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;
    logic              w_unused_imm;
    logic              w_unused_pc;

    // Only part of imm/pc feeds the result; fold the rest away explicitly
    assign w_unused_imm = ^bus.imm;
    assign w_unused_pc  = ^bus.pc;

    assign w_accept  = bus.in_valid & r_in_ready;
    assign w_deliver = r_main_valid & bus.out_ready;

    assign w_sext = DATA_W'($signed(bus.imm[IMM_W-1:0]));
    assign w_zext = DATA_W'(bus.imm[IMM_W-1:0]);

    // Operand formation; illegal modes yield zero
    always_comb begin
        w_result = '0;
        case (bus.mode)
            C_MODE_SEXT: w_result = w_sext;
            C_MODE_BOFS: w_result = w_sext << SHAMT;
            C_MODE_JMP:  w_result = (bus.pc & ~C_JMP_LO_MASK)
                                  | (DATA_W'(bus.imm[JMP_W-1:0]) << SHAMT);
            C_MODE_ZEXT: w_result = w_zext;
            C_MODE_LUI:  w_result = w_zext << IMM_W;
            default:     w_result = '0;
        endcase
    end

    // Next-state of the main/skid pair; skid only fills when main is stuck
    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_data_nxt  = r_main_data;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        if (w_accept && (!r_main_valid || w_deliver)) begin
            w_main_valid_nxt = 1'b1;
            w_main_data_nxt  = w_result;
        end else if (w_accept) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_data_nxt  = w_result;
        end else if (w_deliver && r_skid_valid) begin
            w_main_data_nxt  = r_skid_data;
            w_skid_valid_nxt = 1'b0;
        end else if (w_deliver) begin
            w_main_valid_nxt = 1'b0;
        end
    end

    // Output register, skid register and registered in_ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_in_ready   <= 1'b0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_data  <= w_main_data_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
        end
    end

`ifdef IMM_EXT_ERR_EN
    logic w_illegal;
    assign w_illegal = (bus.mode > C_MODE_LUI);

    // Sticky flag raised by any accepted illegal-mode request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept && w_illegal) begin
            r_err <= 1'b1;
        end
    end
`else
    assign r_err = 1'b0;
`endif

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_main_valid;
    assign bus.out_data  = r_main_data;
    assign bus.err       = r_err;

endmodule
`default_nettype wire
